sop_kernel_engine: RTL

- Parametrised, run-time programmable successor to the fixed combinational benchmark kernels: evaluates a sum-of-products function of N_IN inputs, with terms held in a writable term table.
- Evaluates TERMS_PER_CYC terms per clock, with valid/ready handshakes on input and output.
- Sits beside the mapped kernels as a golden/programmable reference evaluator for equivalence runs.

---
 rtl/sop_kernel_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sop_kernel_engine.sv
// Programmable sum-of-products evaluator with a writable term table.
// Walks the table TERMS_PER_CYC terms per cycle under valid/ready handshakes.
module sop_kernel_engine #(
    parameter  int N_IN          = 15,
    parameter  int N_TERMS       = 16,
    parameter  int TERMS_PER_CYC = 4,
    parameter  int EARLY_EXIT    = 0,
    localparam int AW    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
    localparam int N_GRP = N_TERMS / TERMS_PER_CYC,
    localparam int CW    = $clog2(N_GRP) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic            cfg_en,
    input  logic [N_IN-1:0] cfg_mask,
    input  logic [N_IN-1:0] cfg_pol,
    input  logic            cfg_inv_we,
    input  logic            cfg_inv,
    output logic            cfg_ready,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data,
    output logic [CW-1:0]   out_cycles
);

    if (N_TERMS % TERMS_PER_CYC != 0) begin : g_bad_cfg
        $error("N_TERMS must be a multiple of TERMS_PER_CYC");
    end

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              step;

    logic [N_TERMS-1:0] en_q;
    logic [N_IN-1:0]    mask_q [N_TERMS];
    logic [N_IN-1:0]    pol_q  [N_TERMS];
    logic               inv_q;

    logic [N_IN-1:0]    data_q;
    logic               acc_q;
    logic [CW-1:0]      cnt_q;

    logic [N_TERMS-1:0] term_hit;
    logic               grp_hit;
    logic               cfg_ok;
    logic               addr_ok;

    assign cfg_ok  = (state_q == IDLE);
    assign addr_ok = (int'(cfg_addr) < N_TERMS);

    // Term table and output invert; writable only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= '0;
            inv_q <= 1'b0;
            for (int t = 0; t < N_TERMS; t++) begin
                mask_q[t] <= '0;
                pol_q[t]  <= '0;
            end
        end else if (cfg_ok) begin
            if (cfg_we && addr_ok) begin
                en_q[cfg_addr]   <= cfg_en;
                mask_q[cfg_addr] <= cfg_mask;
                pol_q[cfg_addr]  <= cfg_pol;
            end
            if (cfg_inv_we) begin
                inv_q <= cfg_inv;
            end
        end
    end

    // Every term matched against the captured vector.
    always_comb begin
        term_hit = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            term_hit[t] = en_q[t]
                & ~|((data_q ^ pol_q[t]) & mask_q[t]);
        end
    end

    // OR of the group selected by the cycle count.
    always_comb begin
        grp_hit = 1'b0;
        for (int g = 0; g < N_GRP; g++) begin
            if (cnt_q == CW'(g)) begin
                grp_hit = |term_hit[g*TERMS_PER_CYC +: TERMS_PER_CYC];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                step = 1'b1;
                if (cnt_q == CW'(N_GRP - 1)) begin
                    state_d = DONE;
                end else if ((EARLY_EXIT != 0) && grp_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured vector, OR accumulator and EVAL cycle count.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            acc_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= in_data;
            acc_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (step) begin
            acc_q <= acc_q | grp_hit;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign cfg_ready  = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_data   = out_valid & (acc_q ^ inv_q);
    assign out_cycles = out_valid ? cnt_q : '0;

endmodule
